spi_stream_slave: RTL
=====================

# spi_stream_slave

Parametrised successor to the fixed 16-bit/8-bit SPI slave bridge: an SPI slave that moves Avalon-ST words from the FPGA fabric to the host MCU and returns host bytes as an Avalon-ST source. It supports configurable data width, a TX FIFO depth, all four SPI modes, start-of-frame marking and RX overflow reporting. It sits between the application stream mux and the MCU SPI pins, entirely in the `clk_clk` domain, with oversampled SPI inputs.

## Interface
- `DATA_W`, 16: sink payload width. Must be 8, 16, 24 or 32.
- `CH_W`, 8: sink channel width, 1..8. Zero-extended to one byte on the wire.
- `FIFO_DEPTH`, 16: TX FIFO entries. Power of two, ≥2.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 samples on the leading edge; 1 samples on the trailing edge.
- `IDLE_BYTE`, 8'hFF: MISO byte sent when no word is pending.

Ports:
- `clk_clk`  in  1  system clock; must be ≥8× SCLK.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `sink_ready`  out  1  = !fifo_full.
- `sink_valid`  in  1  word offered.
- `sink_data`  in  DATA_W  payload.
- `sink_channel`  in  CH_W  channel tag.
- `source_ready`  in  1  downstream accepts.
- `source_valid`  out  1  received byte valid.
- `source_data`  out  8  received byte.
- `source_sop`  out  1  byte is the first of an NSS frame.
- `rx_overflow`  out  1  one-cycle pulse when a received byte is dropped.
- `spi_sclk`, `spi_mosi`, `spi_nss`  in  1  asynchronous SPI pins.
- `spi_miso`  inout  1  driven only while NSS is low (as synchronised); Z otherwise.

## Operation
- **Input sync**: SCLK, MOSI and NSS each pass through 2 flip-flops. Edges are detected against a third register.
- **Edge selection**:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, else trailing.
  - Shift edge = the other edge.
- **Frame states**:
  - IDLE: NSS high.
  - LOAD: on NSS fall. Fetch the next TX byte into the shift register. For CPHA=0, drive its MSB immediately.
  - SHIFT: bit counter 0..7. On each sample edge, shift MOSI in (MSB first). On each shift edge, present the next MISO bit. For CPHA=1, the MSB is presented on the first shift edge.
  - After the 8th sample, go back to LOAD for the next byte.
  - NSS rise in any state → IDLE.
- **TX byte source**:
  - A FIFO entry is popped when its channel byte is loaded.
  - The bytes that follow are DATA_W/8 payload bytes, MSB byte first, taken from a holding register.
  - If the FIFO is empty at a word boundary, send IDLE_BYTE.
  - If NSS rises mid-word, the rest of that word is discarded.
- **RX**:
  - The completed byte is written to the source register and `source_valid` is set.
  - `source_sop` = 1 if this is the first byte since NSS fell.
  - If `source_valid`=1 and `source_ready`=0 when a new byte completes, the new byte is dropped and `rx_overflow` pulses.
- **FIFO**:
  - Simultaneous push and pop is allowed when full or empty. The pop sees old data; the push is accepted only if `sink_ready` was high.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB to tell full from empty.

## Timing
- **Reset values**:
  - `source_valid`, `source_sop`, `source_data`, `rx_overflow` = 0.
  - `spi_miso` = Z.
  - FIFO empty, so `sink_ready` = 1.
  - State = IDLE, bit counter = 0.
- **Reset mid-frame**: the frame is aborted and FIFO contents are lost. After release, the block waits for the next NSS fall.
- **Latency**:
  - Pin edge to internal edge detect: 3 clk.
  - MISO update: 1 clk after shift-edge detect.
  - `source_valid` rises 1 clk after the 8th sample-edge detect.
- **Sink**: transfer when `sink_valid` & `sink_ready` at a rising edge of `clk_clk`. The entry is visible to LOAD on the next cycle.
- **Source**: data is held stable while `source_valid` & !`source_ready`. `source_valid` clears on the cycle after acceptance unless a new byte lands on the same cycle.

## Configuration
- `SPISLAVE_STATUS_EN`:
  - Defined: the first MISO byte of every frame is a status byte {sticky rx_overflow since last frame, fifo_empty, fifo_level[5:0] saturated}. Data starts with the second byte, and the sticky flag clears when the status byte loads.
  - Undefined: the first byte is TX data or IDLE_BYTE, and no sticky flag exists.

## Test plan
- **Basic transfer**: push ch=0x03, data=0xA55A; mode 0, 24 SCLKs → MISO bytes 0x03, 0xA5, 0x5A. MOSI bytes 0x11, 0x22, 0x33 appear on source with sop=1, 0, 0.
- **Empty FIFO**: clock 2 bytes → MISO 0xFF, 0xFF.
- **Full FIFO**: 16 pushes → `sink_ready`=0. One pop via SPI → `sink_ready`=1 next clk.
- **Backpressure**: `source_ready`=0 for 2 received bytes → first byte held, `rx_overflow` pulses once.
- **SPI modes**: all four CPOL/CPHA → identical byte streams.
- **Abort**: NSS rises after 12 SCLKs of a word → remainder discarded; the next frame starts with the following entry's channel byte.

Source files
------------

// File: rtl/spi_stream_slave_if.sv
// Stream-side handshake bundle for spi_stream_slave:
// Avalon-ST sink (TX words), Avalon-ST source (RX bytes), overflow pulse.
interface spi_stream_slave_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 8
);
  logic              sink_ready;
  logic              sink_valid;
  logic [DATA_W-1:0] sink_data;
  logic [CH_W-1:0]   sink_channel;
  logic              source_ready;
  logic              source_valid;
  logic [7:0]        source_data;
  logic              source_sop;
  logic              rx_overflow;

  modport slave (
    output sink_ready,
    input  sink_valid, sink_data, sink_channel,
    input  source_ready,
    output source_valid, source_data, source_sop,
    output rx_overflow
  );

  modport master (
    input  sink_ready,
    output sink_valid, sink_data, sink_channel,
    output source_ready,
    input  source_valid, source_data, source_sop,
    input  rx_overflow
  );
endinterface

// File: rtl/spi_stream_slave.sv
// SPI slave bridge: Avalon-ST words out on MISO, MOSI bytes back as a stream.
// Optional macro SPISLAVE_STATUS_EN prefixes each frame with a status byte.
module spi_stream_slave #(
  parameter int         DATA_W     = 16,
  parameter int         CH_W       = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter bit         CPOL       = 1'b0,
  parameter bit         CPHA       = 1'b0,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  spi_stream_slave_if.slave  st,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  input  logic               spi_nss,
  inout  wire                spi_miso
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int EW = CH_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_e;

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] nss_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_q <= {3{CPOL}};
      mosi_q <= '0;
      nss_q  <= '1;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
      nss_q  <= {nss_q[0], spi_nss};
    end
  end

  logic nss_s, mosi_s;
  logic rise_w, fall_w;
  logic lead_w, trail_w;
  logic samp_w, shft_w;

  assign nss_s   = nss_q[1];
  assign mosi_s  = mosi_q[1];
  assign rise_w  = sclk_q[1] & ~sclk_q[2];
  assign fall_w  = ~sclk_q[1] & sclk_q[2];
  assign lead_w  = CPOL ? fall_w : rise_w;
  assign trail_w = CPOL ? rise_w : fall_w;
  assign samp_w  = CPHA ? trail_w : lead_w;
  assign shft_w  = CPHA ? lead_w : trail_w;

  // TX FIFO: {channel, payload}, extra pointer MSB separates full/empty
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          fifo_empty, fifo_full;
  logic          push_w, pop_w;
  logic [EW-1:0] head_w;
  logic [7:0]    ch_byte_w;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_w     = st.sink_valid & ~fifo_full;
  assign head_w     = mem_q[rptr_q[AW-1:0]];
  assign st.sink_ready = ~fifo_full;

  always_comb begin
    ch_byte_w = '0;
    ch_byte_w[CH_W-1:0] = head_w[EW-1 -: CH_W];
  end

  always_ff @(posedge clk_clk) begin
    if (push_w) mem_q[wptr_q[AW-1:0]] <= {st.sink_channel, st.sink_data};
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_w) wptr_q <= wptr_q + 1'b1;
      if (pop_w)  rptr_q <= rptr_q + 1'b1;
    end
  end

  state_e            state_q;
  logic [2:0]        bitcnt_q;
  logic [7:0]        txsh_q;
  logic [7:0]        rxsh_q;
  logic              miso_q;
  logic [DATA_W-1:0] hold_q;
  logic [2:0]        bleft_q;
  logic              first_q;
  logic              src_valid_q;
  logic [7:0]        src_data_q;
  logic              src_sop_q;
  logic              ovf_q;

`ifdef SPISLAVE_STATUS_EN
  logic        stat_pend_q;
  logic        sticky_q;
  logic [AW:0] lvl_w;
  logic [5:0]  lvl6_w;

  assign lvl_w = wptr_q - rptr_q;

  always_comb begin
    if (32'(lvl_w) > 32'd63) lvl6_w = 6'd63;
    else                     lvl6_w = 6'(lvl_w);
  end
`endif

  logic [7:0] ld_byte_w;
  logic       ld_pop_w;
  logic       ld_stat_w;
  logic [7:0] rx_byte_w;
  logic       rx_done_w;

  always_comb begin
    ld_byte_w = IDLE_BYTE;
    ld_pop_w  = 1'b0;
    ld_stat_w = 1'b0;
`ifdef SPISLAVE_STATUS_EN
    if (stat_pend_q) begin
      ld_byte_w = {sticky_q, fifo_empty, lvl6_w};
      ld_stat_w = 1'b1;
    end else
`endif
    if (bleft_q != 3'd0) begin
      ld_byte_w = hold_q[DATA_W-1 -: 8];
    end else if (!fifo_empty) begin
      ld_byte_w = ch_byte_w;
      ld_pop_w  = 1'b1;
    end
  end

  assign pop_w     = (state_q == S_LOAD) & ~nss_s & ld_pop_w;
  assign rx_byte_w = {rxsh_q[6:0], mosi_s};
  assign rx_done_w = (state_q == S_SHIFT) & ~nss_s & samp_w &
                     (bitcnt_q == 3'd7);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      txsh_q      <= '0;
      rxsh_q      <= '0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      bleft_q     <= '0;
      first_q     <= 1'b0;
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      src_sop_q   <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SPISLAVE_STATUS_EN
      stat_pend_q <= 1'b0;
      sticky_q    <= 1'b0;
`endif
    end else begin
      ovf_q <= 1'b0;
      if (st.source_ready) src_valid_q <= 1'b0;
      if (rx_done_w) begin
        if (src_valid_q && !st.source_ready) begin
          ovf_q <= 1'b1;
`ifdef SPISLAVE_STATUS_EN
          sticky_q <= 1'b1;
`endif
        end else begin
          src_valid_q <= 1'b1;
          src_data_q  <= rx_byte_w;
          src_sop_q   <= first_q;
        end
        first_q <= 1'b0;
      end
      if (nss_s) begin
        state_q  <= S_IDLE;
        bitcnt_q <= '0;
        bleft_q  <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_LOAD;
            first_q <= 1'b1;
`ifdef SPISLAVE_STATUS_EN
            stat_pend_q <= 1'b1;
`endif
          end
          S_LOAD: begin
            txsh_q   <= ld_byte_w;
            bitcnt_q <= '0;
            state_q  <= S_SHIFT;
            if (!CPHA) miso_q <= ld_byte_w[7];
            if (ld_stat_w) begin
`ifdef SPISLAVE_STATUS_EN
              stat_pend_q <= 1'b0;
              sticky_q    <= 1'b0;
`endif
            end else if (ld_pop_w) begin
              hold_q  <= head_w[DATA_W-1:0];
              bleft_q <= 3'(NB);
            end else if (bleft_q != 3'd0) begin
              hold_q  <= hold_q << 8;
              bleft_q <= bleft_q - 3'd1;
            end
          end
          S_SHIFT: begin
            if (samp_w) begin
              rxsh_q   <= rx_byte_w;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) state_q <= S_LOAD;
            end
            // CPHA=0: trailing edge after the last sample belongs to the old byte
            if (shft_w) begin
              if (CPHA) begin
                miso_q <= txsh_q[7];
                txsh_q <= txsh_q << 1;
              end else if (bitcnt_q != 3'd0) begin
                miso_q <= txsh_q[6];
                txsh_q <= txsh_q << 1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign st.source_valid = src_valid_q;
  assign st.source_data  = src_data_q;
  assign st.source_sop   = src_sop_q;
  assign st.rx_overflow  = ovf_q;
  assign spi_miso        = nss_s ? 1'bz : miso_q;

endmodule
